// File: rtl/prime_candidate_search.sv
// rtl/prime_candidate_search.sv - random odd candidate generator with small-prime sieve feeding a Miller-Rabin tester
module prime_candidate_search #(
  parameter int                    WORD_WIDTH   = 32,
  parameter logic [WORD_WIDTH-1:0] LFSR_TAPS    = 32'h8020_0003,
  parameter logic [WORD_WIDTH-1:0] LFSR_RESET   = {{(WORD_WIDTH-1){1'b0}}, 1'b1},
  parameter logic [15:0]           MAX_ATTEMPTS = 16'd1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  seed_load,
  input  logic [WORD_WIDTH-1:0] seed,
  input  logic                  start,
  input  logic [1:0]            security_parameter,
  output logic                  busy,
  output logic                  done,
  output logic                  found,
  output logic [WORD_WIDTH-1:0] prime,
  output logic [15:0]           attempts,
  output logic                  mr_enable,
  output logic [WORD_WIDTH-1:0] mr_n,
  output logic [1:0]            mr_security_parameter,
  input  logic                  mr_done,
  input  logic                  mr_is_prime
);

  typedef enum logic [2:0] {IDLE, DRAW, SIEVE, MR_START, MR_WAIT, REJECT, DONE} state_t;

  localparam int                    IDX_W      = $clog2(WORD_WIDTH);
  localparam logic [IDX_W-1:0]      BIT_LAST   = IDX_W'(WORD_WIDTH - 1);
  // Top two bits keep p*q at full length; bit 0 keeps the candidate odd.
  localparam logic [WORD_WIDTH-1:0] FORCE_MASK = {2'b11, {(WORD_WIDTH-3){1'b0}}, 1'b1};
  localparam logic [WORD_WIDTH-1:0] ONE        = {{(WORD_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WORD_WIDTH:0]   TWO        = {{(WORD_WIDTH-1){1'b0}}, 2'b10};
  localparam logic [5:0]            PRIMES [8] = '{6'd3, 6'd5, 6'd7, 6'd11, 6'd13, 6'd17, 6'd19, 6'd23};

  state_t                state;
  logic [WORD_WIDTH-1:0] lfsr;
  logic [WORD_WIDTH-1:0] cand;
  logic [IDX_W-1:0]      bit_idx;
  logic [4:0]            residue      [8];
  logic [4:0]            residue_next [8];
  logic                  any_zero;
  logic                  cur_bit;
  logic [WORD_WIDTH-1:0] lfsr_step;
  logic [WORD_WIDTH:0]   cand_sum;
  logic [15:0]           attempts_inc;

  assign mr_n         = cand;
  assign lfsr_step    = {1'b0, lfsr[WORD_WIDTH-1:1]} ^ (lfsr[0] ? LFSR_TAPS : '0);
  assign cand_sum     = {1'b0, cand} + TWO;
  assign attempts_inc = attempts + 16'd1;
  assign cur_bit      = cand[bit_idx];

  // One MSB-first step of every residue: r = 2r + bit, folded back below p with a single subtract.
  always_comb begin
    logic [5:0] shifted;
    any_zero     = 1'b0;
    residue_next = '{default: '0};
    shifted      = '0;
    for (int i = 0; i < 8; i++) begin
      shifted = {residue[i], cur_bit};
      if (shifted >= PRIMES[i]) residue_next[i] = 5'(shifted - PRIMES[i]);
      else                      residue_next[i] = shifted[4:0];
      if (residue_next[i] == 5'd0) any_zero = 1'b1;
    end
  end

  // Search sequencer: draw, sieve, hand off to Miller-Rabin, step on rejection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                 <= IDLE;
      lfsr                  <= LFSR_RESET;
      cand                  <= '0;
      bit_idx               <= '0;
      for (int i = 0; i < 8; i++) residue[i] <= '0;
      busy                  <= 1'b0;
      done                  <= 1'b0;
      found                 <= 1'b0;
      prime                 <= '0;
      attempts              <= '0;
      mr_enable             <= 1'b0;
      mr_security_parameter <= '0;
    end else begin
      mr_enable <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (seed_load) begin
            lfsr <= (seed == '0) ? ONE : seed;
          end else if (start) begin
            state                 <= DRAW;
            busy                  <= 1'b1;
            attempts              <= '0;
            found                 <= 1'b0;
            mr_security_parameter <= security_parameter;
          end
        end
        DRAW: begin
          cand    <= lfsr | FORCE_MASK;
          lfsr    <= lfsr_step;
          bit_idx <= BIT_LAST;
          for (int i = 0; i < 8; i++) residue[i] <= '0;
          state   <= SIEVE;
        end
        SIEVE: begin
          for (int i = 0; i < 8; i++) residue[i] <= residue_next[i];
          bit_idx <= bit_idx - 1'b1;
          if (bit_idx == '0) begin
            if (any_zero) begin
              state <= REJECT;
            end else begin
              state     <= MR_START;
              mr_enable <= 1'b1;
            end
          end
        end
        MR_START: state <= MR_WAIT;
        MR_WAIT: begin
          if (mr_done) begin
            if (mr_is_prime) begin
              attempts <= attempts_inc;
              found    <= 1'b1;
              prime    <= cand;
              done     <= 1'b1;
              state    <= DONE;
            end else begin
              state <= REJECT;
            end
          end
        end
        REJECT: begin
          attempts <= attempts_inc;
          if (attempts_inc == MAX_ATTEMPTS) begin
            found <= 1'b0;
            prime <= cand;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cand <= cand_sum[WORD_WIDTH-1:0];
            if (cand_sum[WORD_WIDTH]) begin
              state <= DRAW;
            end else begin
              bit_idx <= BIT_LAST;
              for (int i = 0; i < 8; i++) residue[i] <= '0;
              state   <= SIEVE;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prime_candidate_search.sv
// tb/tb_prime_candidate_search.sv - self-checking bench for prime_candidate_search
module tb_prime_candidate_search;

  localparam int W        = 32;
  localparam int MAX_MAIN = 1024;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         seed_load = 1'b0;
  logic [W-1:0] seed = '0;
  logic         start = 1'b0;
  logic [1:0]   security_parameter = 2'd0;
  logic         mr_done = 1'b0;
  logic         mr_is_prime = 1'b0;
  logic         busy, done, found, mr_enable;
  logic [W-1:0] prime, mr_n;
  logic [15:0]  attempts;
  logic [1:0]   mr_security_parameter;

  logic         start3 = 1'b0;
  logic         mr_done3 = 1'b0;
  logic         mr_is_prime3 = 1'b0;
  logic         busy3, done3, found3, mr_enable3;
  logic [W-1:0] prime3, mr_n3;
  logic [15:0]  attempts3;
  logic [1:0]   mr_sp3;

  prime_candidate_search dut (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed), .start(start),
    .security_parameter(security_parameter), .busy(busy), .done(done), .found(found),
    .prime(prime), .attempts(attempts), .mr_enable(mr_enable), .mr_n(mr_n),
    .mr_security_parameter(mr_security_parameter), .mr_done(mr_done), .mr_is_prime(mr_is_prime)
  );

  prime_candidate_search #(.MAX_ATTEMPTS(16'd3)) dut3 (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed), .start(start3),
    .security_parameter(security_parameter), .busy(busy3), .done(done3), .found(found3),
    .prime(prime3), .attempts(attempts3), .mr_enable(mr_enable3), .mr_n(mr_n3),
    .mr_security_parameter(mr_sp3), .mr_done(mr_done3), .mr_is_prime(mr_is_prime3)
  );

  always #5 clk = ~clk;

  int           n_checks = 0;
  int           n_fail = 0;
  logic [W-1:0] lf_model = 1;
  logic [W-1:0] lf3_model = 1;
  int           mr_mode = 0;
  logic [W-1:0] mr_key = '0;
  int           dly[$];

  int           exp_en_cyc[$];
  logic [W-1:0] exp_en_val[$];
  int           exp_done;
  bit           exp_found;
  logic [W-1:0] exp_prime;
  int           exp_att;
  int           obs_en_cyc[$];
  logic [W-1:0] obs_en_val[$];

  function automatic logic [W-1:0] lfsr_next(input logic [W-1:0] v);
    return (v >> 1) ^ (v[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  function automatic bit has_small_factor(input logic [W-1:0] c);
    int unsigned u;
    u = c;
    return (u % 3 == 0) || (u % 5 == 0) || (u % 7 == 0) || (u % 11 == 0) ||
           (u % 13 == 0) || (u % 17 == 0) || (u % 19 == 0) || (u % 23 == 0);
  endfunction

  function automatic bit mr_verdict(input logic [W-1:0] n);
    int unsigned v;
    v = n ^ mr_key;
    if (mr_mode == 0) return n == 32'hC000_0007;
    if (mr_mode == 1) return 1'b0;
    return (v % 4) == 0;
  endfunction

  // Predicts the whole search from the arithmetic rules: candidate list, MR hand-off cycles, result.
  task automatic model_search(input int max_att, inout logic [W-1:0] lf);
    logic [W-1:0] c;
    logic [W:0]   sum;
    int           t, att, k;
    bit           need_draw, fin;
    exp_en_cyc.delete();
    exp_en_val.delete();
    t = 0; att = 0; k = 0; need_draw = 1; fin = 0; c = '0;
    while (!fin) begin
      if (need_draw) begin
        t += 1;
        c = lf | 32'hC000_0001;
        lf = lfsr_next(lf);
        need_draw = 0;
      end
      t += W;
      if (!has_small_factor(c)) begin
        t += 1;
        exp_en_cyc.push_back(t);
        exp_en_val.push_back(c);
        t += (k < dly.size()) ? dly[k] : 1;
        k++;
        if (mr_verdict(c)) begin
          att++; exp_done = t + 1; exp_found = 1; exp_prime = c; exp_att = att;
          fin = 1;
        end
      end
      if (!fin) begin
        t += 1;
        att++;
        if (att == max_att) begin
          exp_done = t + 1; exp_found = 0; exp_prime = c; exp_att = att;
          fin = 1;
        end else begin
          sum = {1'b0, c} + 33'd2;
          c = sum[W-1:0];
          need_draw = sum[W];
        end
      end
    end
  endtask

  task automatic load_seed(input logic [W-1:0] s);
    @(negedge clk);
    seed_load = 1'b1;
    seed = s;
    @(negedge clk);
    seed_load = 1'b0;
    lf_model = (s == '0) ? 1 : s;
    lf3_model = lf_model;
  endtask

  // Runs one search on the main instance with a bench-side Miller-Rabin responder, checking every cycle.
  task automatic run_main(input logic [1:0] sp, input bit noise, input int abort_at);
    int           cyc, k, cnt, ke;
    logic [W-1:0] held;
    bit           waiting, fin, aborted, exp_en;
    cyc = 0; k = 0; cnt = 0; ke = 0; held = '0; waiting = 0; fin = 0; aborted = 0;
    obs_en_cyc.delete();
    obs_en_val.delete();
    model_search(MAX_MAIN, lf_model);
    @(negedge clk);
    start = 1'b1;
    security_parameter = sp;
    while (!fin) begin
      @(negedge clk);
      cyc++;
      mr_done = 1'b0;
      mr_is_prime = 1'b0;
      start = 1'b0;
      if (noise && cyc <= exp_done) begin
        start = 1'($urandom_range(0, 1));
        security_parameter = 2'($urandom);
      end
      exp_en = (ke < exp_en_cyc.size()) && (exp_en_cyc[ke] == cyc);
      n_checks++;
      if (mr_enable !== exp_en) begin
        n_fail++; $display("FAIL mr_enable cycle %0d: got %b expected %b", cyc, mr_enable, exp_en);
      end
      if (mr_enable) begin
        obs_en_cyc.push_back(cyc);
        obs_en_val.push_back(mr_n);
      end
      if (exp_en) begin
        n_checks++;
        if (mr_n !== exp_en_val[ke]) begin
          n_fail++; $display("FAIL mr_n at enable %0d: got %h expected %h", ke, mr_n, exp_en_val[ke]);
        end
        ke++;
      end
      n_checks++;
      if (done !== (cyc == exp_done)) begin
        n_fail++; $display("FAIL done cycle %0d: got %b expected %b", cyc, done, cyc == exp_done);
      end
      n_checks++;
      if (busy !== (cyc <= exp_done)) begin
        n_fail++; $display("FAIL busy cycle %0d: got %b expected %b", cyc, busy, cyc <= exp_done);
      end
      if (cyc <= exp_done) begin
        n_checks++;
        if (mr_security_parameter !== sp) begin
          n_fail++; $display("FAIL mr_security_parameter cycle %0d: got %0d expected %0d", cyc, mr_security_parameter, sp);
        end
      end
      if (waiting) begin
        n_checks++;
        if (mr_n !== held) begin
          n_fail++; $display("FAIL mr_n stable cycle %0d: got %h expected %h", cyc, mr_n, held);
        end
        cnt--;
        if (cnt == 0) begin
          mr_done = 1'b1;
          mr_is_prime = mr_verdict(held);
          waiting = 0;
        end
      end
      if (mr_enable) begin
        held = mr_n;
        waiting = 1;
        cnt = (k < dly.size()) ? dly[k] : 1;
        k++;
      end else if (noise && !waiting && !mr_done && $urandom_range(0, 3) == 0) begin
        mr_done = 1'b1;
        mr_is_prime = 1'b1;
      end
      if (abort_at != 0 && cyc == abort_at) begin
        #2 rst = 1'b1;
        #1;
        n_checks += 4;
        if (busy !== 1'b0)      begin n_fail++; $display("FAIL abort busy: got %b expected 0", busy); end
        if (mr_enable !== 1'b0) begin n_fail++; $display("FAIL abort mr_enable: got %b expected 0", mr_enable); end
        if (done !== 1'b0)      begin n_fail++; $display("FAIL abort done: got %b expected 0", done); end
        if (mr_n !== '0)        begin n_fail++; $display("FAIL abort mr_n: got %h expected 0", mr_n); end
        lf_model = 1;
        lf3_model = 1;
        aborted = 1;
        fin = 1;
      end
      if (cyc >= exp_done + 1) fin = 1;
      if (cyc > 70000) begin
        n_fail++; $display("FAIL search timeout: got %0d cycles expected %0d", cyc, exp_done);
        fin = 1;
      end
    end
    mr_done = 1'b0;
    mr_is_prime = 1'b0;
    start = 1'b0;
    if (!aborted) begin
      n_checks += 4;
      if (found !== exp_found)    begin n_fail++; $display("FAIL found: got %b expected %b", found, exp_found); end
      if (prime !== exp_prime)    begin n_fail++; $display("FAIL prime: got %h expected %h", prime, exp_prime); end
      if (attempts !== 16'(exp_att)) begin n_fail++; $display("FAIL attempts: got %0d expected %0d", attempts, exp_att); end
      if (obs_en_cyc.size() != exp_en_cyc.size()) begin
        n_fail++; $display("FAIL mr_enable count: got %0d expected %0d", obs_en_cyc.size(), exp_en_cyc.size());
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks += 8;
    if (busy !== 1'b0)                  begin n_fail++; $display("FAIL reset busy: got %b expected 0", busy); end
    if (done !== 1'b0)                  begin n_fail++; $display("FAIL reset done: got %b expected 0", done); end
    if (found !== 1'b0)                 begin n_fail++; $display("FAIL reset found: got %b expected 0", found); end
    if (prime !== '0)                   begin n_fail++; $display("FAIL reset prime: got %h expected 0", prime); end
    if (attempts !== '0)                begin n_fail++; $display("FAIL reset attempts: got %0d expected 0", attempts); end
    if (mr_enable !== 1'b0)             begin n_fail++; $display("FAIL reset mr_enable: got %b expected 0", mr_enable); end
    if (mr_n !== '0)                    begin n_fail++; $display("FAIL reset mr_n: got %h expected 0", mr_n); end
    if (mr_security_parameter !== 2'd0) begin n_fail++; $display("FAIL reset mr_sp: got %0d expected 0", mr_security_parameter); end
    @(negedge clk);
    rst = 1'b0;
    lf_model = 1;
    lf3_model = 1;
  endtask

  task automatic test_seed_priority;
    @(negedge clk);
    seed_load = 1'b1;
    seed = 32'h0000_0001;
    start = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    start = 1'b0;
    lf_model = 1;
    lf3_model = 1;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL seed_load priority busy: got %b expected 0", busy); end
  endtask

  task automatic test_known_sequence;
    mr_mode = 0;
    dly.delete();
    repeat (8) dly.push_back(3);
    run_main(2'd2, 0, 0);
    n_checks += 6;
    if (obs_en_cyc.size() != 2) begin
      n_fail++; $display("FAIL known enable count: got %0d expected 2", obs_en_cyc.size());
    end else begin
      if (obs_en_cyc[0] != 34)           begin n_fail++; $display("FAIL known first enable cycle: got %0d expected 34", obs_en_cyc[0]); end
      if (obs_en_val[0] !== 32'hC000_0001) begin n_fail++; $display("FAIL known first mr_n: got %h expected c0000001", obs_en_val[0]); end
      if (obs_en_cyc[1] != 137)          begin n_fail++; $display("FAIL known second enable cycle: got %0d expected 137", obs_en_cyc[1]); end
      if (obs_en_val[1] !== 32'hC000_0007) begin n_fail++; $display("FAIL known second mr_n: got %h expected c0000007", obs_en_val[1]); end
    end
    if (prime !== 32'hC000_0007) begin n_fail++; $display("FAIL known prime: got %h expected c0000007", prime); end
    if (attempts !== 16'd4)      begin n_fail++; $display("FAIL known attempts: got %0d expected 4", attempts); end
  endtask

  task automatic test_wrap;
    load_seed(32'hFFFF_FFFF);
    mr_mode = 2;
    mr_key = $urandom;
    dly.delete();
    repeat (64) dly.push_back(int'($urandom_range(1, 6)));
    run_main(2'd1, 0, 0);
    n_checks++;
    if (obs_en_cyc.size() == 0 || obs_en_cyc[0] < 68 || obs_en_val[0] === 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL wrap first hand-off: got %0d hand-offs expected first at cycle >= 68 after a redraw", obs_en_cyc.size());
    end
  endtask

  task automatic test_security_and_noise;
    load_seed($urandom);
    mr_mode = 2;
    mr_key = $urandom;
    dly.delete();
    repeat (64) dly.push_back(int'($urandom_range(1, 6)));
    run_main(2'd2, 1, 0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 5; i++) begin
      load_seed((i == 0) ? 32'h0 : $urandom);
      mr_mode = 2;
      mr_key = $urandom;
      dly.delete();
      repeat (64) dly.push_back(int'($urandom_range(1, 8)));
      run_main(2'($urandom), 1'($urandom_range(0, 1)), 0);
    end
  endtask

  task automatic test_mr_stall;
    load_seed(32'h1);
    mr_mode = 0;
    dly.delete();
    dly.push_back(500);
    repeat (8) dly.push_back(2);
    run_main(2'd3, 0, 0);
  endtask

  task automatic test_reset_abort;
    load_seed(32'h1);
    mr_mode = 0;
    dly.delete();
    repeat (8) dly.push_back(100);
    run_main(2'd2, 0, 60);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks += 2;
    if (busy !== 1'b0)      begin n_fail++; $display("FAIL post-abort busy: got %b expected 0", busy); end
    if (mr_enable !== 1'b0) begin n_fail++; $display("FAIL post-abort mr_enable: got %b expected 0", mr_enable); end
    test_known_sequence();
  endtask

  task automatic test_max_attempts;
    int cyc, ke, cnt, n_en;
    bit waiting, fin, exp_en;
    load_seed($urandom);
    mr_mode = 1;
    dly.delete();
    repeat (8) dly.push_back(2);
    model_search(3, lf3_model);
    cyc = 0; ke = 0; cnt = 0; n_en = 0; waiting = 0; fin = 0;
    @(negedge clk);
    start3 = 1'b1;
    while (!fin) begin
      @(negedge clk);
      cyc++;
      start3 = 1'b0;
      mr_done3 = 1'b0;
      mr_is_prime3 = 1'b0;
      exp_en = (ke < exp_en_cyc.size()) && (exp_en_cyc[ke] == cyc);
      n_checks += 2;
      if (mr_enable3 !== exp_en) begin n_fail++; $display("FAIL max mr_enable cycle %0d: got %b expected %b", cyc, mr_enable3, exp_en); end
      if (done3 !== (cyc == exp_done)) begin n_fail++; $display("FAIL max done cycle %0d: got %b expected %b", cyc, done3, cyc == exp_done); end
      if (exp_en) ke++;
      if (mr_enable3) n_en++;
      if (waiting) begin
        cnt--;
        if (cnt == 0) begin mr_done3 = 1'b1; waiting = 0; end
      end
      if (mr_enable3) begin waiting = 1; cnt = 2; end
      if (cyc >= exp_done + 1 || cyc > 2000) fin = 1;
    end
    mr_done3 = 1'b0;
    n_checks += 3;
    if (n_en != exp_en_cyc.size()) begin n_fail++; $display("FAIL max enable count: got %0d expected %0d", n_en, exp_en_cyc.size()); end
    if (found3 !== 1'b0)          begin n_fail++; $display("FAIL max found: got %b expected 0", found3); end
    if (attempts3 !== 16'd3)      begin n_fail++; $display("FAIL max attempts: got %0d expected 3", attempts3); end
  endtask

  initial begin
    test_reset();
    test_seed_priority();
    test_known_sequence();
    test_wrap();
    test_security_and_noise();
    test_random();
    test_max_attempts();
    test_mr_stall();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
